// File: rtl/csa_tree_pipe_pkg.sv
// Pipeline placement helpers for the CSA tree: stage count and register positions.
package csa_tree_pipe_pkg;

  function automatic int csa_num_stg(input int num_lvl, input int lps);
    return (num_lvl + lps - 1) / lps;
  endfunction

  // A register closes every lps levels and always after the final level.
  function automatic bit csa_reg_after(input int lvl, input int num_lvl, input int lps);
    return ((lvl + 1) % lps == 0) || (lvl == num_lvl - 1);
  endfunction

  function automatic int csa_stg_of(input int lvl, input int lps);
    return lvl / lps;
  endfunction

endpackage

// File: rtl/fpu_defs_fmac.sv
// Shared FMAC constants and Wallace-tree sizing helpers used by the CSA tree.
package fpu_defs_fmac;

  localparam int C_FMAC_MANT = 23;

  // Operand count entering level lvl when the tree starts with n vectors.
  function automatic int csa_ops(input int n, input int lvl);
    int k;
    k = n;
    for (int i = 0; i < lvl; i++) k = 2 * (k / 3) + (k % 3);
    return k;
  endfunction

  function automatic int csa_levels(input int n);
    int k;
    int l;
    k = n;
    l = 0;
    while (k > 2) begin
      k = 2 * (k / 3) + (k % 3);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Operand/result handshake bundle for csa_tree_pipe.
interface csa_tree_pipe_if #(
  parameter int WIDTH  = 2 * fpu_defs_fmac::C_FMAC_MANT + 3,
  parameter int NUM_PP = 13
);
  logic                         Flush_SI;
  logic                         In_valid_SI;
  logic                         In_ready_SO;
  logic [NUM_PP-1:0][WIDTH-1:0] Pp_index_DI;
  logic                         Out_valid_SO;
  logic                         Out_ready_SI;
  logic [WIDTH-1:0]             Pp_sum_DO;
  logic [WIDTH-1:0]             Pp_carry_DO;
  logic                         MSB_cor_DO;

  modport master (
    output Flush_SI, In_valid_SI, Pp_index_DI, Out_ready_SI,
    input  In_ready_SO, Out_valid_SO, Pp_sum_DO, Pp_carry_DO, MSB_cor_DO
  );

  modport slave (
    input  Flush_SI, In_valid_SI, Pp_index_DI, Out_ready_SI,
    output In_ready_SO, Out_valid_SO, Pp_sum_DO, Pp_carry_DO, MSB_cor_DO
  );
endinterface

// File: rtl/csa_tree_pipe_csa.sv
// 3:2 carry-save adder; carry is returned unshifted so the caller owns alignment.
module csa_tree_pipe_csa #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined Wallace 3:2 tree reducing NUM_PP partial products to a sum/carry pair,
// with per-stage valid bits, backpressure and flush.
module csa_tree_pipe
  import fpu_defs_fmac::*;
  import csa_tree_pipe_pkg::*;
#(
  parameter int WIDTH       = 2 * C_FMAC_MANT + 3,
  parameter int NUM_PP      = 13,
  parameter int LVL_PER_STG = 2
) (
  input logic            Clk_CI,
  input logic            Rst_RI,
  csa_tree_pipe_if.slave bus
);

  localparam int NUM_LVL = csa_levels(NUM_PP);
  localparam int NUM_STG = csa_num_stg(NUM_LVL, LVL_PER_STG);

  logic [NUM_STG-1:0] vld_pipe;
  logic [NUM_STG-1:0] adv;
  logic [NUM_STG-1:0] ld;
  logic               in_ready;

  // Advance resolves from the output back so a full pipe drains in lockstep.
  always_comb begin
    adv = '0;
    adv[NUM_STG-1] = vld_pipe[NUM_STG-1] & bus.Out_ready_SI;
    for (int k = NUM_STG - 2; k >= 0; k--)
      adv[k] = vld_pipe[k] & (~vld_pipe[k+1] | adv[k+1]);
  end

  assign in_ready = ~Rst_RI & ~bus.Flush_SI & (~vld_pipe[0] | adv[0]);

  always_comb begin
    ld    = adv << 1;
    ld[0] = bus.In_valid_SI & in_ready;
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI || bus.Flush_SI) vld_pipe <= '0;
    else                        vld_pipe <= ld | (vld_pipe & ~adv);
  end

  assign bus.In_ready_SO  = in_ready;
  assign bus.Out_valid_SO = vld_pipe[NUM_STG-1];

  for (genvar l = 0; l < NUM_LVL; l++) begin : g_lvl
    localparam int N_IN  = csa_ops(NUM_PP, l);
    localparam int N_GRP = N_IN / 3;
    localparam int N_LFT = N_IN - 3 * N_GRP;
    localparam int N_OUT = csa_ops(NUM_PP, l + 1);
    localparam int STG   = csa_stg_of(l, LVL_PER_STG);

    logic [N_IN-1:0][WIDTH-1:0]  vin;
    logic [N_OUT-1:0][WIDTH-1:0] vout;
    logic [N_OUT-1:0][WIDTH-1:0] nxt;
    logic [N_GRP-1:0]            cout_msb;
    logic                        msb_in;
    logic                        msb_out;
    logic                        nxt_msb;

    if (l == 0) begin : g_src
      assign vin    = bus.Pp_index_DI;
      assign msb_in = 1'b0;
    end else begin : g_chain
      assign vin    = g_lvl[l-1].nxt;
      assign msb_in = g_lvl[l-1].nxt_msb;
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
      logic [WIDTH-1:0] s;
      logic [WIDTH-1:0] c;
      csa_tree_pipe_csa #(.WIDTH(WIDTH)) u_csa (
        .a     (vin[3*g]),
        .b     (vin[3*g+1]),
        .c     (vin[3*g+2]),
        .sum   (s),
        .carry (c)
      );
      // Carry weight-aligned here; the bit pushed past the MSB feeds the correction flag.
      assign vout[2*g]   = s;
      assign vout[2*g+1] = {c[WIDTH-2:0], 1'b0};
      assign cout_msb[g] = c[WIDTH-1];
    end

    for (genvar r = 0; r < N_LFT; r++) begin : g_lft
      assign vout[2*N_GRP+r] = vin[3*N_GRP+r];
    end

    assign msb_out = msb_in | (|cout_msb);

    if (csa_reg_after(l, NUM_LVL, LVL_PER_STG)) begin : g_reg
      always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
          nxt     <= '0;
          nxt_msb <= 1'b0;
        end else if (ld[STG]) begin
          nxt     <= vout;
          nxt_msb <= msb_out;
        end
      end
    end else begin : g_wire
      assign nxt     = vout;
      assign nxt_msb = msb_out;
    end

    if (l == NUM_LVL - 1) begin : g_out
      assign bus.Pp_sum_DO   = nxt[0];
      assign bus.Pp_carry_DO = nxt[1];
      assign bus.MSB_cor_DO  = nxt_msb;
    end
  end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench: directed flow-control cases on the default tree, randomized traffic on a small tree.
module tb_csa_tree_pipe;
  import fpu_defs_fmac::*;

  localparam int WA   = 2 * C_FMAC_MANT + 3;
  localparam int NA   = 13;
  localparam int WB   = 8;
  localparam int NB   = 4;
  localparam int NSET = 10000;
  localparam longint unsigned MASK_A = (64'd1 << WA) - 64'd1;
  localparam longint unsigned MASK_B = (64'd1 << WB) - 64'd1;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csa_tree_pipe_if #(.WIDTH(WA), .NUM_PP(NA)) bus_a ();
  csa_tree_pipe_if #(.WIDTH(WB), .NUM_PP(NB)) bus_b ();

  csa_tree_pipe #(.WIDTH(WA), .NUM_PP(NA), .LVL_PER_STG(2)) u_dut_a (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .bus    (bus_a)
  );

  csa_tree_pipe #(.WIDTH(WB), .NUM_PP(NB), .LVL_PER_STG(1)) u_dut_b (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .bus    (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: plain sum for the invariant, queue-based Wallace reduction for the MSB flag.
  function automatic void tree_ref(input longint unsigned pp[$], input int w,
                                   output longint unsigned tot, output logic msb);
    longint unsigned mask, a, b, c, m;
    longint unsigned cur[$];
    longint unsigned nq[$];
    mask = (64'd1 << w) - 64'd1;
    tot  = '0;
    msb  = 1'b0;
    foreach (pp[i]) tot += pp[i];
    tot &= mask;
    cur = pp;
    while (cur.size() > 2) begin
      nq = {};
      for (int i = 0; i + 2 < cur.size(); i += 3) begin
        a = cur[i];
        b = cur[i+1];
        c = cur[i+2];
        m = (a & b) | (a & c) | (b & c);
        if (((m >> (w - 1)) & 64'd1) != 64'd0) msb = 1'b1;
        nq.push_back(a ^ b ^ c);
        nq.push_back((m << 1) & mask);
      end
      for (int i = cur.size() - (cur.size() % 3); i < cur.size(); i++) nq.push_back(cur[i]);
      cur = nq;
    end
  endfunction

  function automatic logic [63:0] rsum_a();
    return (64'(bus_a.Pp_sum_DO) + 64'(bus_a.Pp_carry_DO)) & MASK_A;
  endfunction

  function automatic logic [63:0] rsum_b();
    return (64'(bus_b.Pp_sum_DO) + 64'(bus_b.Pp_carry_DO)) & MASK_B;
  endfunction

  task automatic rand_a(output longint unsigned pp[$]);
    pp = {};
    for (int i = 0; i < NA; i++) pp.push_back({$urandom, $urandom} & MASK_A);
  endtask

  task automatic drive_a(input longint unsigned pp[$]);
    for (int i = 0; i < NA; i++) bus_a.Pp_index_DI[i] = WA'(pp[i]);
  endtask

  task automatic drive_b(input longint unsigned pp[$]);
    for (int i = 0; i < NB; i++) bus_b.Pp_index_DI[i] = WB'(pp[i]);
  endtask

  // Offer one set to DUT A; returns on the negedge after acceptance.
  task automatic send_a(input longint unsigned pp[$], output bit ok);
    drive_a(pp);
    bus_a.In_valid_SI = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus_a.In_ready_SO) ok = 1'b1;
      @(negedge clk);
    end
    bus_a.In_valid_SI = 1'b0;
  endtask

  // Latency counted in rising edges, the accepting edge included.
  task automatic wait_out_a(output int lat);
    lat = 1;
    while (!bus_a.Out_valid_SO && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned pp[$];
    longint unsigned tot;
    logic            msb;
    longint unsigned e_tot[$];
    logic            e_msb[$];
    bit              ok;
    int              lat, acc, seen, sent, got, cyc;

    rst = 1'b1;
    bus_a.Flush_SI = 1'b0; bus_a.In_valid_SI = 1'b0; bus_a.Out_ready_SI = 1'b1; bus_a.Pp_index_DI = '0;
    bus_b.Flush_SI = 1'b0; bus_b.In_valid_SI = 1'b0; bus_b.Out_ready_SI = 1'b1; bus_b.Pp_index_DI = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  64'(bus_a.In_ready_SO), 64'd0);
    chk("rst_out_valid", 64'(bus_a.Out_valid_SO), 64'd0);
    chk("rst_sum",       64'(bus_a.Pp_sum_DO), 64'd0);
    chk("rst_carry",     64'(bus_a.Pp_carry_DO), 64'd0);
    chk("rst_msb",       64'(bus_a.MSB_cor_DO), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus_a.In_ready_SO), 64'd1);
    @(negedge clk);

    // All partial products equal to one.
    pp = {};
    for (int i = 0; i < NA; i++) pp.push_back(64'd1);
    send_a(pp, ok);
    chk("ones_accept", 64'(ok), 64'd1);
    wait_out_a(lat);
    chk("ones_latency", 64'(lat), 64'd3);
    chk("ones_sum", rsum_a(), 64'd13);
    chk("ones_msb", 64'(bus_a.MSB_cor_DO), 64'd0);
    @(negedge clk);

    // All partial products at the maximum value.
    pp = {};
    for (int i = 0; i < NA; i++) pp.push_back(MASK_A);
    send_a(pp, ok);
    wait_out_a(lat);
    chk("max_latency", 64'(lat), 64'd3);
    chk("max_sum", rsum_a(), MASK_A - 64'd12);
    chk("max_msb", 64'(bus_a.MSB_cor_DO), 64'd1);
    @(negedge clk);

    // Backpressure: five offers against a stalled consumer.
    bus_a.Out_ready_SI = 1'b0;
    e_tot = {}; e_msb = {}; acc = 0;
    rand_a(pp);
    drive_a(pp);
    bus_a.In_valid_SI = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 3) chk("bp_ready_cycle4", 64'(bus_a.In_ready_SO), 64'd0);
      if (bus_a.In_ready_SO) begin
        tree_ref(pp, WA, tot, msb);
        e_tot.push_back(tot);
        e_msb.push_back(msb);
        acc++;
        rand_a(pp);
      end
      @(negedge clk);
      drive_a(pp);
    end
    bus_a.In_valid_SI = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd3);
    if (e_tot.size() == 3) begin
      chk("bp_hold_valid", 64'(bus_a.Out_valid_SO), 64'd1);
      chk("bp_hold_sum0", rsum_a(), e_tot[0]);
      repeat (2) @(negedge clk);
      chk("bp_hold_sum1", rsum_a(), e_tot[0]);
      chk("bp_hold_msb", 64'(bus_a.MSB_cor_DO), 64'(e_msb[0]));
      bus_a.Out_ready_SI = 1'b1;
      for (int j = 0; j < 3; j++) begin
        #1;
        chk("bp_drain_valid", 64'(bus_a.Out_valid_SO), 64'd1);
        chk("bp_drain_sum", rsum_a(), e_tot[j]);
        chk("bp_drain_msb", 64'(bus_a.MSB_cor_DO), 64'(e_msb[j]));
        @(negedge clk);
      end
      #1;
      chk("bp_drain_empty", 64'(bus_a.Out_valid_SO), 64'd0);
    end
    bus_a.Out_ready_SI = 1'b1;
    @(negedge clk);

    // Flush with two sets in flight; the set offered during the flush is dropped.
    acc = 0;
    rand_a(pp);
    drive_a(pp);
    bus_a.In_valid_SI = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (bus_a.In_ready_SO) acc++;
      @(negedge clk);
      rand_a(pp);
      drive_a(pp);
    end
    chk("flush_pre_accepted", 64'(acc), 64'd2);
    bus_a.Flush_SI = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus_a.In_ready_SO), 64'd0);
    @(negedge clk);
    bus_a.Flush_SI = 1'b0;
    bus_a.In_valid_SI = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus_a.Out_valid_SO) seen++;
      @(negedge clk);
    end
    chk("flush_no_output", 64'(seen), 64'd0);
    rand_a(pp);
    tree_ref(pp, WA, tot, msb);
    send_a(pp, ok);
    wait_out_a(lat);
    chk("post_flush_latency", 64'(lat), 64'd3);
    chk("post_flush_sum", rsum_a(), tot);
    chk("post_flush_msb", 64'(bus_a.MSB_cor_DO), 64'(msb));
    @(negedge clk);

    // Flush coinciding with consumer ready discards the presented result.
    bus_a.Out_ready_SI = 1'b0;
    rand_a(pp);
    send_a(pp, ok);
    wait_out_a(lat);
    chk("flush_out_pending", 64'(bus_a.Out_valid_SO), 64'd1);
    bus_a.Flush_SI = 1'b1;
    bus_a.Out_ready_SI = 1'b1;
    @(negedge clk);
    bus_a.Flush_SI = 1'b0;
    #1;
    chk("flush_out_dropped", 64'(bus_a.Out_valid_SO), 64'd0);
    @(negedge clk);

    // Reset in the middle of an operation, with flush also high.
    rand_a(pp);
    send_a(pp, ok);
    rst = 1'b1;
    bus_a.Flush_SI = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_a.Flush_SI = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus_a.Out_valid_SO), 64'd0);
    chk("midrst_sum",   64'(bus_a.Pp_sum_DO), 64'd0);
    chk("midrst_carry", 64'(bus_a.Pp_carry_DO), 64'd0);
    chk("midrst_msb",   64'(bus_a.MSB_cor_DO), 64'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus_a.Out_valid_SO) seen++;
    end
    chk("midrst_no_output", 64'(seen), 64'd0);

    // Small tree: single set latency.
    pp = {};
    for (int i = 0; i < NB; i++) pp.push_back(64'($urandom_range(0, 255)));
    tree_ref(pp, WB, tot, msb);
    drive_b(pp);
    bus_b.In_valid_SI = 1'b1;
    #1;
    chk("b_ready", 64'(bus_b.In_ready_SO), 64'd1);
    @(negedge clk);
    bus_b.In_valid_SI = 1'b0;
    lat = 1;
    while (!bus_b.Out_valid_SO && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b_latency", 64'(lat), 64'd2);
    chk("b_single_sum", rsum_b(), tot);
    chk("b_single_msb", 64'(bus_b.MSB_cor_DO), 64'(msb));
    @(negedge clk);

    // Small tree: random traffic and random consumer stalls, in-order scoreboard.
    sent = 0; got = 0; cyc = 0;
    e_tot = {}; e_msb = {};
    while (got < NSET && cyc < 60000) begin
      pp = {};
      for (int i = 0; i < NB; i++)
        pp.push_back(($urandom_range(0, 7) == 0) ? 64'd255 : 64'($urandom_range(0, 255)));
      drive_b(pp);
      bus_b.In_valid_SI  = (sent < NSET) && ($urandom_range(0, 9) < 8);
      bus_b.Out_ready_SI = ($urandom_range(0, 9) < 7);
      #1;
      if (bus_b.In_valid_SI && bus_b.In_ready_SO) begin
        tree_ref(pp, WB, tot, msb);
        e_tot.push_back(tot);
        e_msb.push_back(msb);
        sent++;
      end
      if (bus_b.Out_valid_SO && bus_b.Out_ready_SI) begin
        if (e_tot.size() == 0) begin
          chk("b_spurious_out", 64'd1, 64'd0);
        end else begin
          chk("b_rand_sum", rsum_b(), e_tot.pop_front());
          chk("b_rand_msb", 64'(bus_b.MSB_cor_DO), 64'(e_msb.pop_front()));
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus_b.In_valid_SI = 1'b0;
    chk("b_rand_count", 64'(got), 64'(NSET));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/csa_tree_pipe.md
CSA_TREE_PIPE -- requirements
Module: csa_tree_pipe

Interface
REQ-001: Parameter WIDTH, default 2*C_FMAC_MANT+3, bit width of each partial product and of both outputs.
REQ-002: Parameter NUM_PP, default 13, number of partial products; legal range 3..32.
REQ-003: Parameter LVL_PER_STG, default 2, CSA levels between pipeline registers; legal range 1..8.
REQ-004: Clk_CI  in  1  single clock; all state on rising edge.
REQ-005: Rst_RI  in  1  reset; one clock, reset is synchronous and active-high.
REQ-006: Flush_SI  in  1  synchronous discard of all in-flight operations.
REQ-007: In_valid_SI  in  1  input operand set valid.
REQ-008: In_ready_SO  out  1  block accepts an operand set this cycle.
REQ-009: Pp_index_DI  in  NUM_PP x WIDTH  partial products.
REQ-010: Out_valid_SO  out  1  result valid.
REQ-011: Out_ready_SI  in  1  consumer accepts result.
REQ-012: Pp_sum_DO  out  WIDTH  redundant sum vector.
REQ-013: Pp_carry_DO  out  WIDTH  redundant carry vector, already weight-aligned (no further shift by consumer).
REQ-014: MSB_cor_DO  out  1  OR of every carry bit shifted out of bit WIDTH-1 anywhere in the tree.

Function
REQ-015: Tree SHALL be Wallace-style: at each level, operands grouped in threes from index 0 upward, each group reduced by one 3:2 CSA, leftovers (1 or 2) passed unchanged; repeat until two vectors remain.
REQ-016: Every CSA carry SHALL be shifted left by one with bit 0 = 0 before the next level; the shifted-out bit SHALL be ORed into the MSB_cor term of that operand set.
REQ-017: NUM_LVL derived at elaboration; NUM_STG = ceil(NUM_LVL/LVL_PER_STG); defaults give NUM_LVL=5, NUM_STG=3.
REQ-018: Latency SHALL be exactly NUM_STG cycles from accepted input to Out_valid_SO with Out_ready_SI held high.
REQ-019: Invariant: (Pp_sum_DO + Pp_carry_DO) mod 2^WIDTH == (sum of all Pp_index_DI) mod 2^WIDTH.
REQ-020: Each stage holds a valid bit; stage k advances when stage k+1 is empty or advancing; In_ready_SO = !valid[0] | stage 0 advancing (no combinational path from In_valid_SI to In_ready_SO).
REQ-021: Throughput one set per cycle while Out_ready_SI high; with Out_ready_SI low, exactly NUM_STG sets buffered, then In_ready_SO low.
REQ-022: Out_valid_SO high SHALL hold Pp_sum_DO, Pp_carry_DO, MSB_cor_DO stable until Out_ready_SI high.
REQ-023: Flush_SI clears all valid bits next cycle; In_ready_SO SHALL be low in the flush cycle; input offered that cycle is dropped.
REQ-024: Simultaneous Flush_SI and Out_ready_SI: current output is not consumed; it is discarded.
REQ-025: Datapath registers SHALL load only on advance; no enable-free toggling of held data.

Reset
REQ-026: Rst_RI high: all stage valid bits 0, Out_valid_SO 0, In_ready_SO 0 during reset, 1 first cycle after.
REQ-027: Pp_sum_DO, Pp_carry_DO, MSB_cor_DO SHALL reset to 0.
REQ-028: Reset mid-operation SHALL discard all in-flight sets; Rst_RI dominates Flush_SI.

Structure
REQ-029: C_FMAC_MANT and any tree-depth helper function live in fpu_defs_fmac; no local redefinition.
REQ-030: Existing CSA module SHALL be the only sub-module, instantiated via generate per level/group.
REQ-031: Level count and register placement computed by elaboration-time functions; no hand-unrolled levels.

Verification
REQ-032: Defaults, Pp_index_DI[i]=1 for all 13, Out_ready_SI=1 -> after 3 cycles sum+carry=13, MSB_cor_DO=0.
REQ-033: Defaults, all Pp = 2^WIDTH-1 -> sum+carry mod 2^WIDTH = 2^WIDTH-13, MSB_cor_DO=1.
REQ-034: Out_ready_SI=0, 5 back-to-back inputs -> 3 accepted, In_ready_SO low cycle 4; release -> 3 results in order, 1/cycle.
REQ-035: Flush_SI pulse with 2 sets in flight -> no Out_valid_SO for them; next set returns 3 cycles after acceptance.
REQ-036: NUM_PP=4, LVL_PER_STG=1, WIDTH=8, random 10k sets with random Out_ready_SI -> REQ-019 holds, latency 2 (NUM_LVL=2), order kept.
